// File: rtl/mos6502_sequencer.sv
// Multi-cycle fetch/operand/execute control sequencer for the mos6502 core.
// Decodes the opcode each cycle and drives IR, memory, address-mux, PC and register loads.
module mos6502_sequencer #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rdy,
   input  logic [7:0]       opcode,
   input  logic             flag_z,
   input  logic             flag_c,
   output logic             il,
   output logic             mw,
   output logic             mm,
   output logic [1:0]       ps,
   output logic             a_load,
   output logic             alu_add,
   output logic             adl_load,
   output logic             adh_load,
   output logic             sync,
   output logic             halted,
   output logic [2:0]       state_dbg,
   output logic [CNT_W-1:0] instr_cnt
);

   localparam logic [2:0] ST_INF = 3'd0;
   localparam logic [2:0] ST_OP1 = 3'd1;
   localparam logic [2:0] ST_OP2 = 3'd2;
   localparam logic [2:0] ST_EX0 = 3'd3;
   localparam logic [2:0] ST_HLT = 3'd7;

   localparam logic       IL_NOLOAD = 1'b0;
   localparam logic       IL_LOAD   = 1'b1;
   localparam logic       MW_WRITE  = 1'b0;
   localparam logic       MW_READ   = 1'b1;
   localparam logic       MM_PC     = 1'b0;
   localparam logic       MM_A      = 1'b1;
   localparam logic [1:0] PS_HOLD   = 2'd0;
   localparam logic [1:0] PS_INC    = 2'd1;
   localparam logic [1:0] PS_REL    = 2'd2;
   localparam logic [1:0] PS_ABS    = 2'd3;

   localparam logic [7:0] OP_NOP     = 8'hEA;
   localparam logic [7:0] OP_LDA_IMM = 8'hA9;
   localparam logic [7:0] OP_ADC_IMM = 8'h69;
   localparam logic [7:0] OP_LDA_ABS = 8'hAD;
   localparam logic [7:0] OP_STA_ABS = 8'h8D;
   localparam logic [7:0] OP_JMP_ABS = 8'h4C;
   localparam logic [7:0] OP_BEQ     = 8'hF0;
   localparam logic [7:0] OP_BNE     = 8'hD0;
   localparam logic [7:0] OP_BCS     = 8'hB0;

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             take;

   assign take = ((opcode == OP_BEQ) &&  flag_z) ||
                 ((opcode == OP_BNE) && !flag_z) ||
                 ((opcode == OP_BCS) &&  flag_c);

   always_comb begin
      il       = IL_NOLOAD;
      mw       = MW_READ;
      mm       = MM_PC;
      ps       = PS_HOLD;
      a_load   = 1'b0;
      alu_add  = 1'b0;
      adl_load = 1'b0;
      adh_load = 1'b0;
      sync     = 1'b0;
      state_d  = state_q;
      cnt_d    = cnt_q;
      case (state_q)
         ST_INF: begin
            il      = IL_LOAD;
            ps      = PS_INC;
            sync    = 1'b1;
            state_d = ST_OP1;
            cnt_d   = cnt_q + 1'b1;
         end
         ST_OP1: begin
            case (opcode)
               OP_NOP: state_d = ST_INF;
               OP_LDA_IMM, OP_ADC_IMM: begin
                  a_load  = 1'b1;
                  alu_add = (opcode == OP_ADC_IMM);
                  ps      = PS_INC;
                  state_d = ST_INF;
               end
               OP_LDA_ABS, OP_STA_ABS, OP_JMP_ABS: begin
                  adl_load = 1'b1;
                  ps       = PS_INC;
                  state_d  = ST_OP2;
               end
               OP_BEQ, OP_BNE, OP_BCS: begin
                  ps      = take ? PS_REL : PS_INC;
                  state_d = ST_INF;
               end
               default: state_d = ST_HLT;
            endcase
         end
         ST_OP2: begin
            adh_load = 1'b1;
            if (opcode == OP_JMP_ABS) begin
               ps      = PS_ABS;
               state_d = ST_INF;
            end else begin
               ps      = PS_INC;
               state_d = ST_EX0;
            end
         end
         ST_EX0: begin
            mm = MM_A;
            if (opcode == OP_STA_ABS) begin
               mw = MW_WRITE;
            end else begin
               a_load = 1'b1;
            end
            state_d = ST_INF;
         end
         ST_HLT: state_d = ST_HLT;
         default: state_d = ST_HLT;
      endcase

      // Stall or reset: the cycle has no side effects and repeats once released.
      if (reset || !rdy) begin
         il       = IL_NOLOAD;
         mw       = MW_READ;
         mm       = MM_PC;
         ps       = PS_HOLD;
         a_load   = 1'b0;
         alu_add  = 1'b0;
         adl_load = 1'b0;
         adh_load = 1'b0;
         sync     = 1'b0;
         state_d  = state_q;
         cnt_d    = cnt_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_INF;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign halted    = (state_q == ST_HLT) && !reset;
   assign state_dbg = state_q;
   assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_mos6502_sequencer.sv
// Directed bench for mos6502_sequencer: reset, each opcode class, branches, stall, halt, wrap.
// Counter width is reduced to 4 so the wrap case is reached quickly.
module tb_mos6502_sequencer;

   localparam int unsigned CW = 4;

   localparam logic       RD  = 1'b1;
   localparam logic       WR  = 1'b0;
   localparam logic [1:0] HLD = 2'd0;
   localparam logic [1:0] INC = 2'd1;
   localparam logic [1:0] REL = 2'd2;
   localparam logic [1:0] ABS = 2'd3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          rdy = 1'b1;
   logic [7:0]    opcode = 8'hEA;
   logic          flag_z = 1'b0;
   logic          flag_c = 1'b0;
   logic          il, mw, mm, a_load, alu_add, adl_load, adh_load, sync, halted;
   logic [1:0]    ps;
   logic [2:0]    state_dbg;
   logic [CW-1:0] instr_cnt;

   int n_total = 0;
   int n_bad   = 0;
   logic [CW-1:0] exp_cnt = '0;

   mos6502_sequencer #(.CNT_W(CW)) dut (
      .clk       (clk),
      .reset     (reset),
      .rdy       (rdy),
      .opcode    (opcode),
      .flag_z    (flag_z),
      .flag_c    (flag_c),
      .il        (il),
      .mw        (mw),
      .mm        (mm),
      .ps        (ps),
      .a_load    (a_load),
      .alu_add   (alu_add),
      .adl_load  (adl_load),
      .adh_load  (adh_load),
      .sync      (sync),
      .halted    (halted),
      .state_dbg (state_dbg),
      .instr_cnt (instr_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Packed view: {il, mw, mm, ps, a_load, alu_add, adl_load, adh_load, sync, halted, state}
   function automatic logic [13:0] ov(input logic il_e, input logic mw_e, input logic mm_e,
                                      input logic [1:0] ps_e, input logic al, input logic aa,
                                      input logic adl, input logic adh, input logic sy,
                                      input logic hl, input logic [2:0] st);
      return {il_e, mw_e, mm_e, ps_e, al, aa, adl, adh, sy, hl, st};
   endfunction

   task automatic chk_o(input string tag, input logic [13:0] exp);
      chk(tag, {18'b0, il, mw, mm, ps, a_load, alu_add, adl_load, adh_load, sync, halted,
                state_dbg}, {18'b0, exp});
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Present an opcode during INF, check the fetch cycle, then step into OP1.
   task automatic fetch(input logic [7:0] op);
      opcode = op;
      #1;
      chk_o("inf_outs", ov(1, RD, 0, INC, 0, 0, 0, 0, 1, 0, 3'd0));
      cyc();
      exp_cnt = exp_cnt + 1'b1;
      chk("cnt_after_fetch", {28'b0, instr_cnt}, {28'b0, exp_cnt});
   endtask

   task automatic branch(input string tag, input logic [7:0] op, input logic z, input logic c,
                         input logic [1:0] exp_ps);
      flag_z = z;
      flag_c = c;
      fetch(op);
      chk_o(tag, ov(0, RD, 0, exp_ps, 0, 0, 0, 0, 0, 0, 3'd1));
      cyc();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk_o("reset_outs", ov(0, RD, 0, HLD, 0, 0, 0, 0, 0, 0, 3'd0));
      chk("reset_cnt", {28'b0, instr_cnt}, 32'd0);
      reset = 1'b0;

      // NOP loop: 2 cycles each, counter climbs to all-ones then wraps.
      for (int i = 1; i <= 15; i++) begin
         fetch(8'hEA);
         if (i == 1) chk_o("nop_op1", ov(0, RD, 0, HLD, 0, 0, 0, 0, 0, 0, 3'd1));
         cyc();
         if (i == 1) chk("nop_back_inf", {29'b0, state_dbg}, 32'd0);
      end
      fetch(8'hEA);
      chk("cnt_wrap", {28'b0, instr_cnt}, 32'd0);
      cyc();

      fetch(8'hA9);
      chk_o("lda_imm_op1", ov(0, RD, 0, INC, 1, 0, 0, 0, 0, 0, 3'd1));
      cyc();
      fetch(8'h69);
      chk_o("adc_imm_op1", ov(0, RD, 0, INC, 1, 1, 0, 0, 0, 0, 3'd1));
      cyc();

      fetch(8'hAD);
      chk_o("lda_abs_op1", ov(0, RD, 0, INC, 0, 0, 1, 0, 0, 0, 3'd1));
      cyc();
      chk_o("lda_abs_op2", ov(0, RD, 0, INC, 0, 0, 0, 1, 0, 0, 3'd2));
      cyc();
      chk_o("lda_abs_ex0", ov(0, RD, 1, HLD, 1, 0, 0, 0, 0, 0, 3'd3));
      cyc();
      chk("lda_abs_end", {29'b0, state_dbg}, 32'd0);

      fetch(8'h8D);
      cyc();
      chk_o("sta_abs_op2", ov(0, RD, 0, INC, 0, 0, 0, 1, 0, 0, 3'd2));
      cyc();
      chk_o("sta_abs_ex0", ov(0, WR, 1, HLD, 0, 0, 0, 0, 0, 0, 3'd3));
      cyc();

      fetch(8'h4C);
      chk_o("jmp_op1", ov(0, RD, 0, INC, 0, 0, 1, 0, 0, 0, 3'd1));
      cyc();
      chk_o("jmp_op2", ov(0, RD, 0, ABS, 0, 0, 0, 1, 0, 0, 3'd2));
      cyc();
      chk("jmp_end", {29'b0, state_dbg}, 32'd0);

      branch("beq_taken",  8'hF0, 1, 0, REL);
      branch("beq_not",    8'hF0, 0, 1, INC);
      branch("bne_not",    8'hD0, 1, 0, INC);
      branch("bne_taken",  8'hD0, 0, 1, REL);
      branch("bcs_taken",  8'hB0, 0, 1, REL);
      branch("bcs_not",    8'hB0, 1, 0, INC);

      // Stall in INF: no fetch, no count.
      rdy = 1'b0;
      #1;
      chk_o("stall_inf_outs", ov(0, RD, 0, HLD, 0, 0, 0, 0, 0, 0, 3'd0));
      cyc();
      chk("stall_inf_cnt", {28'b0, instr_cnt}, {28'b0, exp_cnt});
      rdy = 1'b1;

      // STA held in EX0 for three stalled cycles; the write lands only once released.
      fetch(8'h8D);
      cyc();
      cyc();
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk_o("sta_stall_ex0", ov(0, RD, 0, HLD, 0, 0, 0, 0, 0, 0, 3'd3));
         cyc();
      end
      rdy = 1'b1;
      #1;
      chk_o("sta_release", ov(0, WR, 1, HLD, 0, 0, 0, 0, 0, 0, 3'd3));
      cyc();
      chk("sta_stall_end", {29'b0, state_dbg}, 32'd0);

      // Unsupported opcode halts; counter frozen.
      fetch(8'h02);
      chk_o("bad_op1", ov(0, RD, 0, HLD, 0, 0, 0, 0, 0, 0, 3'd1));
      cyc();
      chk_o("halt_outs", ov(0, RD, 0, HLD, 0, 0, 0, 0, 0, 1, 3'd7));
      repeat (10) cyc();
      chk_o("halt_stays", ov(0, RD, 0, HLD, 0, 0, 0, 0, 0, 1, 3'd7));
      chk("halt_cnt", {28'b0, instr_cnt}, {28'b0, exp_cnt});

      // Asynchronous reset takes effect between clock edges.
      #1;
      reset = 1'b1;
      #1;
      chk("async_state", {29'b0, state_dbg}, 32'd0);
      chk("async_cnt", {28'b0, instr_cnt}, 32'd0);
      chk("async_halted", {31'b0, halted}, 32'd0);
      cyc();
      reset = 1'b0;
      exp_cnt = '0;

      // Reset in EX0 of a store abandons it without a write.
      fetch(8'h8D);
      cyc();
      cyc();
      reset = 1'b1;
      #1;
      chk_o("reset_mid_sta", ov(0, RD, 0, HLD, 0, 0, 0, 0, 0, 0, 3'd0));
      cyc();
      reset = 1'b0;
      exp_cnt = '0;
      fetch(8'hEA);
      chk("post_reset_cnt", {28'b0, instr_cnt}, 32'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1);
   end

endmodule

// File: doc/mos6502_sequencer.md
Name: mos6502_sequencer

Overview:
- Multi-cycle control sequencer for the mos6502 core.
- Decodes the instruction register (opcode) and steps a fetch/operand/execute state machine.
- Drives the existing datapath controls: IR load (il_t), memory read/write (mw_t), address mux (mm_t), PC control (ps_t), A-register load, ALU op and address-register byte loads.
- Sits between the instruction register/flags and the PC, memory and register file. Supports a stall input and halts on unsupported opcodes.

Parameters:
- CNT_W, 16, width of retired-instruction counter

Ports:
- clk  in  1  system clock, all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- rdy  in  1  memory ready; 0 = stall current cycle
- opcode  in  8 (opc_t)  instruction register contents, stable from OP1 onward
- flag_z  in  1  zero flag
- flag_c  in  1  carry flag
- il  out  1 (il_t)  IR load control
- mw  out  1 (mw_t)  memory WRITE/READ
- mm  out  1 (mm_t)  address source PC_ADDR/A_ADDR
- ps  out  2 (ps_t)  PC control HOLD/INC/REL/ABS
- a_load  out  1  load accumulator from ALU result at edge
- alu_add  out  1  0 = ALU passes data bus, 1 = A + data + C
- adl_load  out  1  load address-register low byte from data bus
- adh_load  out  1  load address-register high byte from data bus
- sync  out  1  high during opcode-fetch cycle
- halted  out  1  high in HLT state
- state_dbg  out  3  INF=0, OP1=1, OP2=2, EX0=3, HLT=7
- instr_cnt  out  CNT_W  count of completed opcode fetches

Behaviour:
- States are INF, OP1, OP2, EX0 and HLT. Outputs are combinational from state, opcode and flags; the state register and instr_cnt are flopped.
- Default outputs: il=NOLOAD, mw=READ, mm=PC_ADDR, ps=HOLD, all loads 0, alu_add=0, sync=0, halted=0.
- Reset (asynchronous): state=INF, instr_cnt=0. While reset is high, all outputs are forced to defaults, including sync=0.
- Reset mid-instruction abandons the instruction; no WRITE is issued while reset is high.
- Stall: when rdy=0, state and instr_cnt hold and outputs are forced to defaults except state_dbg/halted. No write or load occurs on a stalled cycle. The same cycle re-executes when rdy returns to 1.
- INF: mm=PC_ADDR, READ, il=LOAD, ps=INC, sync=1. Go to OP1. instr_cnt+1 (wraps at all-ones to 0).
- OP1 (decode opcode):
  - 0xEA NOP: ps=HOLD. Go to INF.
  - 0xA9 LDA #: READ at PC, a_load=1, alu_add=0, ps=INC. Go to INF.
  - 0x69 ADC #: as LDA # with alu_add=1. Go to INF.
  - 0xAD, 0x8D, 0x4C: adl_load=1, ps=INC. Go to OP2.
  - 0xF0 BEQ (take if Z=1), 0xD0 BNE (take if Z=0), 0xB0 BCS (take if C=1): ps=REL if taken, else ps=INC. Go to INF.
  - REL means PC := PC + 1 + sign-extended data bus.
  - Any other opcode: ps=HOLD. Go to HLT.
- OP2 (always reads at PC with adh_load=1):
  - 0x4C JMP: ps=ABS (PC := {data, adl}). Go to INF.
  - 0xAD, 0x8D: ps=INC. Go to EX0.
- EX0 (mm=A_ADDR):
  - 0xAD LDA abs: READ, a_load=1, alu_add=0.
  - 0x8D STA abs: mw=WRITE.
  - ps=HOLD for both. Go to INF.
- HLT: defaults plus halted=1. Exit only by reset; instr_cnt frozen.
- Cycle counts with rdy=1: NOP/imm/branch = 2, JMP = 3, LDA/STA abs = 4.
- Flags are sampled only in OP1 of a branch.

Test Plan:
- Reset high 3 cycles then low, rdy=1, opcode=0xEA: state_dbg 0,1,0,1…; sync pulses every 2nd cycle; instr_cnt increments 1,2,…
- opcode=0xAD, rdy=1: sequence INF→OP1(adl_load)→OP2(adh_load, ps=INC)→EX0(mm=A_ADDR, READ, a_load=1)→INF; 4 cycles; 0x8D identical but EX0 mw=WRITE, a_load=0.
- opcode=0xF0: with flag_z=1, OP1 ps=REL; with flag_z=0, OP1 ps=INC. Opcode 0xD0 gives the inverse; 0xB0 with flag_c=1 gives ps=REL.
- STA abs with rdy=0 held 3 cycles in EX0: state_dbg stays 3, mw=READ throughout the stall; mw=WRITE only on the first rdy=1 cycle, then INF.
- opcode=0x02 after fetch: OP1→HLT; halted=1, state_dbg=7, instr_cnt frozen for 10 cycles; async reset clears to INF/0 without waiting for a clock edge.
- instr_cnt preset by running 0xFFFF NOP fetches (or CNT_W=4, 15 fetches): next INF wraps instr_cnt to 0.
